pheap_level: RTL

- Generic intermediate or last level (LEVEL ≥ 2) of the pipelined heap priority queue. It is the responder side of the level-to-level protocol that the root level drives.
- Owns node storage for its level and serves synchronous child-pair reads to the level above.
- Executes the LEQ/DEQ token handed down by the level above, then issues a token to the level below.
- Levels chain root → pheap_level(2) → … → pheap_level(LEVELS).

---
 rtl/pheap_level_pkg.sv | 36 +++
 rtl/pheap_level_mem.sv | 47 ++++
 rtl/pheap_level.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/pheap_level_pkg.sv
// Shared types and constants for the pipelined heap levels.
package pheap_level_pkg;

  localparam int PQ_LEVELS = 3;
  localparam int KEY_W     = 8;
  localparam int VAL_W     = 8;
  localparam int CAP_W     = PQ_LEVELS;

  typedef enum logic { LEQ = 1'b0, DEQ = 1'b1 } opcode_t;

  typedef enum logic [1:0] {
    DONE       = 2'd0,
    WAIT       = 2'd1,
    NEXT_LEVEL = 2'd2
  } done_t;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] val;
  } kv_t;

  typedef struct packed {
    kv_t              kv;
    logic [CAP_W-1:0] cap;
    logic             active;
  } entry_t;

  localparam kv_t    KV_EMPTY    = '{key: '0, val: '0};
  localparam entry_t ENTRY_EMPTY = '{kv: KV_EMPTY, cap: '0, active: 1'b0};

  // Free slots in the subtree rooted at a node of the given level.
  function automatic logic [CAP_W-1:0] cap_max(input int levels, input int level);
    cap_max = CAP_W'((1 << (levels - level + 1)) - 1);
  endfunction

endpackage

// File: rtl/pheap_level_mem.sv
// Node storage for one heap level: combinational own-node read, registered
// child-pair read for the level above, one write port, write-first pair read.
module pheap_level_mem
  import pheap_level_pkg::*;
#(
  parameter int     AW   = 1,
  parameter entry_t INIT = ENTRY_EMPTY
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wen,
  input  logic [AW-1:0] waddr,
  input  entry_t        wdata,
  input  logic [AW-1:0] raddr,
  output entry_t        rdata,
  input  logic [AW-1:0] pair_addr,
  output entry_t        rd_l,
  output entry_t        rd_r
);

  localparam int N = 1 << AW;

  entry_t mem_q [N];
  entry_t mem_d [N];

  // Storage next-state: the pending write, shared by storage and pair read.
  always_comb begin
    for (int i = 0; i < N; i++) mem_d[i] = mem_q[i];
    if (wen) mem_d[waddr] = wdata;
  end

  assign rdata = mem_q[raddr];

  // Storage update and write-first registered pair read.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) mem_q[i] <= INIT;
      rd_l <= ENTRY_EMPTY;
      rd_r <= ENTRY_EMPTY;
    end else begin
      for (int i = 0; i < N; i++) mem_q[i] <= mem_d[i];
      rd_l <= mem_d[pair_addr];
      rd_r <= mem_d[pair_addr | AW'(1)];
    end
  end

endmodule

// File: rtl/pheap_level.sv
// Generic intermediate / last level of the pipelined heap priority queue.
// Optional protocol checker: define PHEAP_LEVEL_CHK_EN to enable the sticky err flag.
//
// Token handshake: start is a one-cycle pulse accepted only in IDLE (there is
// no ready; the upper level keeps tokens >= 2 cycles apart). On acceptance
// raddr_dn presents the node index to the lower level, whose registered
// child pair arrives in EXEC. start_dn is likewise a one-cycle pulse in EXEC.
module pheap_level
  import pheap_level_pkg::*;
#(
  parameter int LEVELS = PQ_LEVELS,
  parameter int LEVEL  = 2,
  parameter bit LAST   = 1'b0,
  localparam int AW    = LEVEL - 1,
  localparam int RW    = (LEVEL > 2) ? LEVEL - 2 : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  opcode_t          op,
  input  kv_t              kv_in,
  input  logic [AW-1:0]    idx_in,
  input  logic [RW-1:0]    raddr_up,
  output entry_t           rBotL_up,
  output entry_t           rBotR_up,
  output logic [AW-1:0]    raddr_dn,
  input  entry_t           rBotL_dn,
  input  entry_t           rBotR_dn,
  output logic             start_dn,
  output opcode_t          op_dn,
  output kv_t              kv_dn,
  output logic [LEVEL-1:0] idx_dn,
  output done_t            done,
  output logic             err
);

  localparam logic [CAP_W-1:0] CAP_MAX   = cap_max(LEVELS, LEVEL);
  localparam entry_t           NODE_INIT = '{kv: KV_EMPTY, cap: CAP_MAX, active: 1'b0};

  typedef enum logic { IDLE = 1'b0, EXEC = 1'b1 } state_t;

  state_t        state_q, state_d;
  opcode_t       op_q;
  kv_t           kv_q;
  logic [AW-1:0] idx_q;

  entry_t           node, wdata, child_l, child_r;
  logic             wen;
  logic [CAP_W-1:0] cap_dec, cap_inc;
  logic             leq_right, deq_left;
  kv_t              keep, push;

  pheap_level_mem #(.AW(AW), .INIT(NODE_INIT)) u_mem (
    .clk       (clk),
    .rst       (rst),
    .wen       (wen),
    .waddr     (idx_q),
    .wdata     (wdata),
    .raddr     (idx_q),
    .rdata     (node),
    .pair_addr (AW'({raddr_up, 1'b0})),
    .rd_l      (rBotL_up),
    .rd_r      (rBotR_up)
  );

  // The last level has no children: they look empty and full.
  assign child_l = LAST ? ENTRY_EMPTY : rBotL_dn;
  assign child_r = LAST ? ENTRY_EMPTY : rBotR_dn;

  assign cap_dec   = (node.cap == '0) ? '0 : node.cap - CAP_W'(1);
  assign cap_inc   = (node.cap >= CAP_MAX) ? CAP_MAX : node.cap + CAP_W'(1);
  assign leq_right = !((child_l.cap >= child_r.cap) && (child_l.cap != '0));
  assign deq_left  = child_l.active && (!child_r.active || (child_l.kv.key >= child_r.kv.key));

  // State register and token latch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= LEQ;
      kv_q    <= KV_EMPTY;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        op_q  <= op;
        kv_q  <= kv_in;
        idx_q <= idx_in;
      end
    end
  end

  // Next state, node write and downstream token.
  always_comb begin
    state_d  = state_q;
    start_dn = 1'b0;
    op_dn    = LEQ;
    kv_dn    = KV_EMPTY;
    idx_dn   = '0;
    raddr_dn = '0;
    done     = DONE;
    wen      = 1'b0;
    wdata    = node;
    keep     = node.kv;
    push     = kv_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = EXEC;
          raddr_dn = idx_in;
          done     = WAIT;
        end
      end
      EXEC: begin
        state_d = IDLE;
        wen     = 1'b1;
        if (op_q == LEQ) begin
          if (!node.active) begin
            wdata = '{kv: kv_q, cap: cap_dec, active: 1'b1};
          end else begin
            // Larger key stays; ties keep the resident value.
            if (kv_q.key > node.kv.key) begin
              keep = kv_q;
              push = node.kv;
            end
            wdata = '{kv: keep, cap: cap_dec, active: 1'b1};
            if (!LAST) begin
              start_dn = 1'b1;
              op_dn    = LEQ;
              kv_dn    = push;
              idx_dn   = {idx_q, leq_right};
              done     = NEXT_LEVEL;
            end
          end
        end else begin
          if (!child_l.active && !child_r.active) begin
            wdata = '{kv: KV_EMPTY, cap: cap_inc, active: 1'b0};
          end else begin
            wdata    = '{kv: (deq_left ? child_l.kv : child_r.kv), cap: cap_inc, active: 1'b1};
            start_dn = 1'b1;
            op_dn    = DEQ;
            idx_dn   = {idx_q, !deq_left};
            done     = NEXT_LEVEL;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Reset in EXEC cancels both the node write and the downstream token.
    if (!rst) begin
      start_dn = 1'b0;
      wen      = 1'b0;
    end
  end

`ifdef PHEAP_LEVEL_CHK_EN
  logic err_q, err_set;

  // Protocol violations observable at this level.
  always_comb begin
    err_set = 1'b0;
    if (state_q == EXEC) begin
      if (start) err_set = 1'b1;
      if (op_q == LEQ && node.cap == '0) err_set = 1'b1;
      if (op_q == DEQ && !node.active) err_set = 1'b1;
      if (op_q == LEQ && !LAST && child_l.cap == '0 && child_r.cap == '0) err_set = 1'b1;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst) err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
